// File: rtl/dram_wr_arbiter.sv
// Round-robin burst write arbiter (A/B) plus read sequencer in front of a 2048x16 dual-port RAM.
// Latency: req in IDLE at t -> ack t+1 -> RAM write t+2; read data one cycle after rd_req.
// Backpressure: x_ack follows x_req only while x holds the grant; reads never stall. Option: DRAM_ARB_BYPASS_EN.
module dram_wr_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_last,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ack,
  input  logic              b_req,
  input  logic              b_last,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_vld,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;        // 0: A wins a tie, 1: B wins a tie
  logic [CNT_W-1:0] burst_cnt;
  logic             xfer;
  logic             xfer_last;
  logic             release_gnt;

  assign xfer        = (a_req & a_ack) | (b_req & b_ack);
  assign xfer_last   = (a_ack & a_last) | (b_ack & b_last);
  // The transfer that brings the count to MAX_BURST closes the grant.
  assign release_gnt = xfer & (xfer_last | (burst_cnt == CNT_W'(MAX_BURST - 1)));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (a_req && b_req) state_nxt = ptr ? GNT_B : GNT_A;
        else if (a_req)     state_nxt = GNT_A;
        else if (b_req)     state_nxt = GNT_B;
      end
      GNT_A, GNT_B: begin
        if (release_gnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_ack = 1'b0;
    b_ack = 1'b0;
    case (state)
      GNT_A:   a_ack = a_req;
      GNT_B:   b_ack = b_req;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= 1'b0;
      burst_cnt <= '0;
    end else if (release_gnt) begin
      ptr       <= a_ack;
      burst_cnt <= '0;
    end else if (xfer) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_wr_en <= xfer;
      if (xfer) begin
        ram_wr_addr <= a_ack ? a_addr : b_addr;
        ram_wr_data <= a_ack ? a_data : b_data;
      end
    end
  end

  assign ram_rd_addr = rd_addr;

  always_ff @(posedge clk) begin
    if (rst) rd_vld <= 1'b0;
    else     rd_vld <= rd_req;
  end

`ifdef DRAM_ARB_BYPASS_EN
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;

  // Write-first: a read colliding with the pending write returns the new data.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit <= ram_wr_en && (ram_wr_addr == rd_addr);
      if (ram_wr_en && (ram_wr_addr == rd_addr)) byp_data <= ram_wr_data;
    end
  end

  assign rd_data = byp_hit ? byp_data : ram_rd_data;
`else
  assign rd_data = ram_rd_data;
`endif

endmodule

// File: tb/tb_dram_wr_arbiter.sv
// Scoreboard bench for dram_wr_arbiter with a behavioural read-first RAM attached.
module tb_dram_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req = 1'b0, a_last = 1'b0, a_ack;
  logic [10:0] a_addr = '0;
  logic [15:0] a_data = '0;
  logic        b_req = 1'b0, b_last = 1'b0, b_ack;
  logic [10:0] b_addr = '0;
  logic [15:0] b_data = '0;
  logic        rd_req = 1'b0, rd_vld;
  logic [10:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        ram_wr_en;
  logic [10:0] ram_wr_addr, ram_rd_addr;
  logic [15:0] ram_wr_data, ram_rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [26:0] wq[$];
  logic [15:0] rq[$];
  int          acycs[$];
  int          bcycs[$];
  logic [15:0] mem [2048];

  dram_wr_arbiter #(.ADDR_W(11), .DATA_W(16), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_last(a_last), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_last(b_last), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_vld(rd_vld), .rd_data(rd_data),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'h0000;
    end else if (ram_wr_en) begin
      mem[ram_wr_addr] <= ram_wr_data;
    end
    ram_rd_data <= mem[ram_rd_addr];
  end

  // Monitor: compares RAM writes and read returns against the scoreboard queues.
  always @(negedge clk) begin
    logic [26:0] w;
    logic [15:0] r;
    if (a_ack) acycs.push_back(cyc);
    if (b_ack) bcycs.push_back(cyc);
    n_tests++;
    if (a_ack && b_ack) begin
      n_fail++;
      $display("FAIL ack_exclusive a_ack=%b b_ack=%b required not both", a_ack, b_ack);
    end
    if (ram_wr_en) begin
      n_tests++;
      if (wq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%h data=%h", ram_wr_addr, ram_wr_data);
      end else begin
        w = wq.pop_front();
        if ({ram_wr_addr, ram_wr_data} !== w) begin
          n_fail++;
          $display("FAIL ram_write got %h/%h required %h/%h", ram_wr_addr, ram_wr_data, w[26:16], w[15:0]);
        end
      end
    end
    if (rd_vld) begin
      n_tests++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rd_vld data=%h", rd_data);
      end else begin
        r = rq.pop_front();
        if (rd_data !== r) begin
          n_fail++;
          $display("FAIL rd_data got %h required %h", rd_data, r);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_req = 0; a_last = 0; b_req = 0; b_last = 0; rd_req = 0;
    step(2);
    rst = 1'b0;
    acycs.delete();
    bcycs.delete();
  endtask

  task automatic set_req(input bit sel, input bit req, input bit lst,
                         input logic [10:0] ad, input logic [15:0] dt);
    if (!sel) begin a_req = req; a_last = lst; a_addr = ad; a_data = dt; end
    else      begin b_req = req; b_last = lst; b_addr = ad; b_data = dt; end
  endtask

  // Presents n words, waits for each ack, scoreboards each accepted word.
  task automatic drive_burst(input bit sel, input int n, input logic [10:0] addr0,
                             input logic [15:0] data0, input bit use_last);
    for (int i = 0; i < n; i++) begin
      logic [10:0] ad;
      logic [15:0] dt;
      bit          done;
      int          waited;
      ad = addr0 + 11'(i);
      dt = data0 - 16'(i);
      done = 0;
      waited = 0;
      set_req(sel, 1'b1, use_last && (i == n - 1), ad, dt);
      while (!done) begin
        @(negedge clk);
        if (sel ? b_ack : a_ack) begin
          wq.push_back({ad, dt});
          done = 1;
        end
        step(1);
        if (!done && ++waited > 200) begin
          n_tests++; n_fail++;
          $display("FAIL burst_timeout sel=%0d word=%0d got no ack required ack within 200", sel, i);
          set_req(sel, 1'b0, 1'b0, '0, '0);
          return;
        end
      end
    end
    set_req(sel, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic drain_check(input string name);
    step(3);
    n_tests++;
    if (wq.size() != 0 || rq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain pending wr=%0d rd=%0d required 0/0", name, wq.size(), rq.size());
      wq.delete();
      rq.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({a_ack, b_ack, ram_wr_en, rd_vld} !== 4'b0 || ram_wr_addr !== 11'h0 || ram_wr_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b%b wr_en=%b rd_vld=%b addr=%h data=%h required all 0",
               a_ack, b_ack, ram_wr_en, rd_vld, ram_wr_addr, ram_wr_data);
    end
    n_tests++;
    if (dut.state !== 2'd0 || dut.ptr !== 1'b0 || dut.burst_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_state got state=%0d ptr=%b cnt=%0d required 0/0/0", dut.state, dut.ptr, dut.burst_cnt);
    end
  endtask

  task automatic test_a_burst();
    int t0;
    do_reset();
    t0 = cyc;
    drive_burst(1'b0, 4, 11'h010, 16'hFFFF, 1'b1);
    n_tests++;
    if (acycs.size() != 4 || acycs[0] != t0 + 1 || acycs[3] != t0 + 4) begin
      n_fail++;
      $display("FAIL a_burst_acks got n=%0d first=%0d required n=4 first=%0d",
               acycs.size(), (acycs.size() > 0) ? acycs[0] - t0 : -1, 1);
    end
    n_tests++;
    if (bcycs.size() != 0) begin
      n_fail++;
      $display("FAIL a_burst_b_ack got %0d b acks required 0", bcycs.size());
    end
    drain_check("a_burst");
    n_tests++;
    if (dut.state !== 2'd0) begin
      n_fail++;
      $display("FAIL a_burst_idle got state=%0d required 0", dut.state);
    end
  endtask

  task automatic test_both();
    int t0;
    do_reset();
    t0 = cyc;
    fork
      drive_burst(1'b0, 3, 11'h020, 16'hA000, 1'b1);
      drive_burst(1'b1, 3, 11'h040, 16'hB000, 1'b1);
    join
    n_tests++;
    if (acycs.size() != 3 || bcycs.size() != 3 || acycs[0] != t0 + 1 || bcycs[0] != t0 + 5) begin
      n_fail++;
      $display("FAIL both_order got a0=%0d b0=%0d required a0=1 b0=5",
               (acycs.size() > 0) ? acycs[0] - t0 : -1, (bcycs.size() > 0) ? bcycs[0] - t0 : -1);
    end
    acycs.delete();
    bcycs.delete();
    t0 = cyc;
    fork
      drive_burst(1'b0, 2, 11'h060, 16'hC000, 1'b1);
      drive_burst(1'b1, 2, 11'h070, 16'hD000, 1'b1);
    join
    n_tests++;
    if (acycs.size() != 2 || bcycs.size() != 2 || acycs[0] != t0 + 1 || bcycs[0] != t0 + 4) begin
      n_fail++;
      $display("FAIL both_pointer got a0=%0d b0=%0d required a0=1 b0=4",
               (acycs.size() > 0) ? acycs[0] - t0 : -1, (bcycs.size() > 0) ? bcycs[0] - t0 : -1);
    end
    drain_check("both");
  endtask

  task automatic test_back_to_back();
    int t0;
    do_reset();
    t0 = cyc;
    drive_burst(1'b0, 2, 11'h080, 16'h1000, 1'b1);
    drive_burst(1'b0, 2, 11'h090, 16'h2000, 1'b1);
    n_tests++;
    if (acycs.size() != 4 || acycs[1] != t0 + 2 || acycs[2] != t0 + 4) begin
      n_fail++;
      $display("FAIL back_to_back got n=%0d second_burst=%0d required n=4 second_burst=4",
               acycs.size(), (acycs.size() > 2) ? acycs[2] - t0 : -1);
    end
    drain_check("back_to_back");
  endtask

  task automatic test_max_burst();
    int t0;
    do_reset();
    t0 = cyc;
    fork
      drive_burst(1'b0, 40, 11'h100, 16'h8000, 1'b0);
      drive_burst(1'b1, 3, 11'h180, 16'h9000, 1'b1);
    join
    n_tests++;
    if (acycs.size() != 40 || bcycs.size() != 3) begin
      n_fail++;
      $display("FAIL max_burst_count got a=%0d b=%0d required a=40 b=3", acycs.size(), bcycs.size());
    end else begin
      n_tests++;
      if (acycs[15] != t0 + 16 || bcycs[0] != t0 + 18 || acycs[16] != t0 + 22) begin
        n_fail++;
        $display("FAIL max_burst_timing got a16=%0d b1=%0d a17=%0d required 16/18/22",
                 acycs[15] - t0, bcycs[0] - t0, acycs[16] - t0);
      end
    end
    drain_check("max_burst");
  endtask

  task automatic test_bypass();
    logic [15:0] exp_hit;
    do_reset();
`ifdef DRAM_ARB_BYPASS_EN
    exp_hit = 16'h1234;
`else
    exp_hit = 16'h0000;
`endif
    drive_burst(1'b0, 1, 11'h055, 16'h1234, 1'b1);
    rd_req = 1'b1; rd_addr = 11'h055;
    rq.push_back(exp_hit);
    @(negedge clk);
    n_tests++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== 11'h055 || ram_rd_addr !== 11'h055) begin
      n_fail++;
      $display("FAIL collision_setup got wr_en=%b wr=%h rd=%h required 1/055/055", ram_wr_en, ram_wr_addr, ram_rd_addr);
    end
    step(1);
    rq.push_back(16'h1234);
    step(1);
    rd_req = 1'b0;
    drain_check("bypass");
  endtask

  task automatic test_rst_mid_burst();
    do_reset();
    set_req(1'b0, 1'b1, 1'b0, 11'h300, 16'h5555);
    step(1);
    @(negedge clk);
    n_tests++;
    if (a_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_first_ack got %b required 1", a_ack);
    end else wq.push_back({11'h300, 16'h5555});
    step(1);
    set_req(1'b0, 1'b1, 1'b0, 11'h301, 16'h5554);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    set_req(1'b0, 1'b1, 1'b1, 11'h200, 16'hAAAA);
    @(negedge clk);
    n_tests++;
    if (a_ack !== 1'b0 || ram_wr_en !== 1'b0 || dut.state !== 2'd0 || dut.ptr !== 1'b0 || dut.burst_cnt !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_state got ack=%b wr_en=%b state=%0d ptr=%b cnt=%0d required 0/0/0/0/0",
               a_ack, ram_wr_en, dut.state, dut.ptr, dut.burst_cnt);
    end
    step(1);
    @(negedge clk);
    n_tests++;
    if (a_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_regrant got %b required 1", a_ack);
    end else wq.push_back({11'h200, 16'hAAAA});
    step(1);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    drain_check("rst_mid");
  endtask

  task automatic test_sweep();
    do_reset();
    drive_burst(1'b0, 2048, 11'h000, 16'hFFFF, 1'b0);
    step(2);
    for (int i = 0; i < 2048; i++) begin
      rd_req = 1'b1;
      rd_addr = 11'(i);
      rq.push_back(16'hFFFF - 16'(i));
      step(1);
    end
    rd_req = 1'b0;
    drain_check("sweep");
  endtask

  initial begin
    test_reset();
    test_a_burst();
    test_both();
    test_back_to_back();
    test_max_burst();
    test_bypass();
    test_rst_mid_burst();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
